// File: rtl/sha256_w_scheduler.sv
// SHA-256 message schedule generator: loads 16 words, then streams W[0..ROUNDS-1]
// computing each new word in place over a 16-word sliding window.
module sha256_w_scheduler #(
  parameter int ROUNDS = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_wt,
  output logic [5:0]  out_t,
  output logic        out_last
);

  typedef enum logic {LOAD, STREAM} state_t;

  localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic [5:0]  t_reg, t_next;
  logic [31:0] window_reg  [16];
  logic [31:0] window_next [16];
  logic [31:0] w_new;

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  // window[0] is W[t], so window[15] receives W[t+16] after the shift.
  assign w_new = sig1(window_reg[14]) + window_reg[9] + sig0(window_reg[1]) + window_reg[0];

  assign in_ready  = (state_reg == LOAD);
  assign out_valid = (state_reg == STREAM);
  assign out_wt    = window_reg[0];
  assign out_t     = t_reg;
  assign out_last  = (state_reg == STREAM) && (t_reg == LAST_T);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    t_next     = t_reg;
    for (int i = 0; i < 16; i++) begin
      window_next[i] = window_reg[i];
    end

    if (flush) begin
      state_next = LOAD;
      cnt_next   = 4'd0;
      t_next     = 6'd0;
      for (int i = 0; i < 16; i++) begin
        window_next[i] = 32'd0;
      end
    end else begin
      case (state_reg)
        LOAD: begin
          if (in_valid) begin
            window_next[cnt_reg] = in_word;
            if (cnt_reg == 4'd15) begin
              state_next = STREAM;
              cnt_next   = 4'd0;
              t_next     = 6'd0;
            end else begin
              cnt_next = cnt_reg + 4'd1;
            end
          end
        end
        STREAM: begin
          if (out_ready) begin
            for (int i = 0; i < 15; i++) begin
              window_next[i] = window_reg[i + 1];
            end
            window_next[15] = w_new;
            if (t_reg == LAST_T) begin
              state_next = LOAD;
              cnt_next   = 4'd0;
              t_next     = 6'd0;
            end else begin
              t_next = t_reg + 6'd1;
            end
          end
        end
        default: begin
          state_next = LOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= LOAD;
      cnt_reg   <= 4'd0;
      t_reg     <= 6'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      t_reg     <= t_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_window
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          window_reg[gi] <= 32'd0;
        end else begin
          window_reg[gi] <= window_next[gi];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_sha256_w_scheduler.sv
// Directed bench for sha256_w_scheduler: a 64-round instance and a 20-round instance
// checked against a reference SHA-256 schedule built in the bench.
module tb_sha256_w_scheduler;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, flush;
  logic [31:0] in_word;
  logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, out_last_a;
  logic [31:0] out_wt_a;
  logic [5:0]  out_t_a;
  logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, out_last_b;
  logic [31:0] out_wt_b;
  logic [5:0]  out_t_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] blk   [16];
  logic [31:0] exp_w [64];
  logic [31:0] cap   [64];

  sha256_w_scheduler #(.ROUNDS(64)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_word(in_word),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_wt(out_wt_a),
    .out_t(out_t_a), .out_last(out_last_a)
  );

  sha256_w_scheduler #(.ROUNDS(20)) dut_b (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_word(in_word),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_wt(out_wt_b),
    .out_t(out_t_b), .out_last(out_last_b)
  );

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  task automatic build_model();
    for (int i = 0; i < 16; i++) exp_w[i] = blk[i];
    for (int i = 16; i < 64; i++)
      exp_w[i] = ssig1(exp_w[i-2]) + exp_w[i-7] + ssig0(exp_w[i-15]) + exp_w[i-16];
  endtask

  task automatic set_abc();
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    build_model();
  endtask

  task automatic set_fill(input logic [31:0] v);
    for (int i = 0; i < 16; i++) blk[i] = v;
    build_model();
  endtask

  task automatic set_pattern(input logic [31:0] seed);
    for (int i = 0; i < 16; i++) blk[i] = seed ^ (32'h01010101 * i) ^ (32'h9E3779B9 << (i % 5));
    build_model();
  endtask

  function automatic logic get_ov(input int sel);
    return (sel != 0) ? out_valid_b : out_valid_a;
  endfunction
  function automatic logic get_ir(input int sel);
    return (sel != 0) ? in_ready_b : in_ready_a;
  endfunction
  function automatic logic get_ol(input int sel);
    return (sel != 0) ? out_last_b : out_last_a;
  endfunction
  function automatic logic [31:0] get_wt(input int sel);
    return (sel != 0) ? out_wt_b : out_wt_a;
  endfunction
  function automatic logic [5:0] get_t(input int sel);
    return (sel != 0) ? out_t_b : out_t_a;
  endfunction

  task automatic set_iv(input int sel, input logic v);
    if (sel != 0) in_valid_b = v; else in_valid_a = v;
  endtask
  task automatic set_or(input int sel, input logic v);
    if (sel != 0) out_ready_b = v; else out_ready_a = v;
  endtask

  // Presents the 16 words of blk; optional idle gap after word index gap_after.
  task automatic load_block(input int sel, input int gap_after, input int gap_len, input string name);
    for (int i = 0; i < 16; i++) begin
      set_iv(sel, 1'b1);
      in_word = blk[i];
      @(negedge clk);
      if (i == gap_after) begin
        for (int g = 0; g < gap_len; g++) begin
          set_iv(sel, 1'b0);
          in_word = $urandom;
          @(negedge clk);
          checks++;
          if (get_ov(sel) !== 1'b0 || get_ir(sel) !== 1'b1) begin
            errors++;
            $display("FAIL %s gap: out_valid=%b in_ready=%b, required 0/1", name, get_ov(sel), get_ir(sel));
          end
        end
      end
    end
    set_iv(sel, 1'b0);
    checks++;
    if (get_ov(sel) !== 1'b1 || get_ir(sel) !== 1'b0) begin
      errors++;
      $display("FAIL %s first_beat: out_valid=%b in_ready=%b, required 1/0", name, get_ov(sel), get_ir(sel));
    end
    $display("%s: loaded 16 words", name);
  endtask

  // mode 0: always ready; mode 1: random ready with a 5-cycle hold at hold_t.
  task automatic run_stream(input int sel, input int rounds, input int mode, input int hold_t,
                            input int stop_at, input bit keep_iv, input string name);
    int t = 0;
    int cyc = 0;
    int hold = 0;
    logic rdy;
    while (t < stop_at && cyc < 1000) begin
      if (keep_iv) begin
        set_iv(sel, 1'b1);
        in_word = $urandom;
      end
      checks++;
      if (get_ov(sel) !== 1'b1 || get_t(sel) !== 6'(t) || get_wt(sel) !== exp_w[t] ||
          get_ol(sel) !== (t == rounds - 1) || get_ir(sel) !== 1'b0) begin
        errors++;
        $display("FAIL %s beat: out_valid=%b out_t=%0d out_wt=%08h out_last=%b in_ready=%b, required 1/%0d/%08h/%b/0",
                 name, get_ov(sel), get_t(sel), get_wt(sel), get_ol(sel), get_ir(sel),
                 t, exp_w[t], (t == rounds - 1));
      end
      cap[t] = get_wt(sel);
      if (mode == 0) rdy = 1'b1;
      else if (t == hold_t && hold < 5) begin
        rdy = 1'b0;
        hold++;
      end else rdy = 1'($urandom_range(0, 1));
      set_or(sel, rdy);
      @(negedge clk);
      if (rdy) t++;
      cyc++;
    end
    set_or(sel, 1'b0);
    set_iv(sel, 1'b0);
    if (cyc >= 1000) begin
      errors++;
      $display("FAIL %s timeout: reached t=%0d, required %0d", name, t, stop_at);
    end
    if (stop_at == rounds) begin
      checks++;
      if (get_ir(sel) !== 1'b1 || get_ov(sel) !== 1'b0) begin
        errors++;
        $display("FAIL %s end_to_load: in_ready=%b out_valid=%b, required 1/0", name, get_ir(sel), get_ov(sel));
      end
    end
    $display("%s: streamed to t=%0d in %0d cycles", name, t, cyc);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; in_word = 32'd0;
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_valid_b = 1'b0; out_ready_b = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (get_ir(s) !== 1'b1 || get_ov(s) !== 1'b0 || get_wt(s) !== 32'd0 ||
          get_t(s) !== 6'd0 || get_ol(s) !== 1'b0) begin
        errors++;
        $display("FAIL reset dut%0d: ir=%b ov=%b wt=%08h t=%0d last=%b, required 1/0/0/0/0",
                 s, get_ir(s), get_ov(s), get_wt(s), get_t(s), get_ol(s));
      end
    end
    reset_n = 1'b1;
    $display("reset: checked");
  endtask

  task automatic test_abc();
    set_abc();
    load_block(0, -1, 0, "abc");
    run_stream(0, 64, 0, 0, 64, 1'b0, "abc");
    checks++;
    if (cap[0] !== 32'h61626380 || cap[15] !== 32'h00000018) begin
      errors++;
      $display("FAIL abc_w0_w15: got %08h %08h, required 61626380 00000018", cap[0], cap[15]);
    end
    checks++;
    if (cap[16] !== 32'h61626380 || cap[17] !== 32'h000F0000 || cap[18] !== 32'h7DA86405) begin
      errors++;
      $display("FAIL abc_w16_18: got %08h %08h %08h, required 61626380 000F0000 7DA86405",
               cap[16], cap[17], cap[18]);
    end
  endtask

  task automatic test_backpressure();
    set_abc();
    load_block(0, -1, 0, "backpressure");
    run_stream(0, 64, 1, 16, 64, 1'b0, "backpressure");
  endtask

  task automatic test_input_gaps();
    set_pattern(32'h0BADF00D);
    load_block(0, 7, 3, "gaps");
    run_stream(0, 64, 0, 0, 64, 1'b1, "gaps");
  endtask

  task automatic test_back_to_back();
    set_fill(32'h00000000);
    load_block(0, -1, 0, "b2b_zero");
    run_stream(0, 64, 0, 0, 64, 1'b0, "b2b_zero");
    set_fill(32'hFFFFFFFF);
    load_block(0, -1, 0, "b2b_ones");
    run_stream(0, 64, 0, 0, 64, 1'b0, "b2b_ones");
  endtask

  task automatic test_flush_load();
    set_pattern(32'h13572468);
    for (int i = 0; i < 9; i++) begin
      in_valid_a = 1'b1;
      in_word = blk[i];
      @(negedge clk);
    end
    flush = 1'b1;
    in_word = 32'hDEADBEEF;
    @(negedge clk);
    flush = 1'b0;
    in_valid_a = 1'b0;
    checks++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || out_wt_a !== 32'd0) begin
      errors++;
      $display("FAIL flush_load: ir=%b ov=%b wt=%08h, required 1/0/00000000", in_ready_a, out_valid_a, out_wt_a);
    end
    set_pattern(32'hCAFEBABE);
    load_block(0, -1, 0, "flush_load");
    run_stream(0, 64, 0, 0, 64, 1'b0, "flush_load");
  endtask

  task automatic test_flush_stream();
    set_abc();
    load_block(0, -1, 0, "flush_stream");
    run_stream(0, 64, 0, 0, 30, 1'b0, "flush_stream");
    flush = 1'b1;
    out_ready_a = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    out_ready_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_t_a !== 6'd0 || out_wt_a !== 32'd0) begin
      errors++;
      $display("FAIL flush_stream: ov=%b ir=%b t=%0d wt=%08h, required 0/1/0/00000000",
               out_valid_a, in_ready_a, out_t_a, out_wt_a);
    end
    set_pattern(32'h55AA33CC);
    load_block(0, -1, 0, "after_flush");
    run_stream(0, 64, 0, 0, 64, 1'b0, "after_flush");
  endtask

  task automatic test_reset_stream();
    set_abc();
    load_block(0, -1, 0, "reset_stream");
    run_stream(0, 64, 0, 0, 10, 1'b0, "reset_stream");
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_t_a !== 6'd0 || out_wt_a !== 32'd0) begin
      errors++;
      $display("FAIL reset_stream: ov=%b ir=%b t=%0d wt=%08h, required 0/1/0/00000000",
               out_valid_a, in_ready_a, out_t_a, out_wt_a);
    end
    @(negedge clk);
    reset_n = 1'b1;
    set_pattern(32'h0F0F1234);
    load_block(0, -1, 0, "after_reset");
    run_stream(0, 64, 0, 0, 64, 1'b0, "after_reset");
  endtask

  task automatic test_rounds20();
    set_abc();
    load_block(1, -1, 0, "rounds20");
    run_stream(1, 20, 0, 0, 20, 1'b0, "rounds20");
  endtask

  initial begin
    test_reset();
    test_abc();
    test_backpressure();
    test_input_gaps();
    test_back_to_back();
    test_flush_load();
    test_flush_stream();
    test_reset_stream();
    test_rounds20();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
